// File: rtl/student_iis_tdm_transceiver.sv
// rtl/student_iis_tdm_transceiver.sv - I2S/TDM serial transceiver with one-frame TX holding register
// Counters track the data-bit position; lrclk leads them by one BCLK in I2S mode.
module student_iis_tdm_transceiver #(
    parameter int NUM_CH   = 2,
    parameter int TX_W     = 24,
    parameter int RX_W     = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4,
    parameter int I2S_MODE = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [NUM_CH*TX_W-1:0]   tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic [NUM_CH*RX_W-1:0]   rx_data_o,
    output logic                     rx_valid_o,
    output logic                     bclk_o,
    output logic                     lrclk_o,
    output logic                     dac_sdata_o,
    input  logic                     adc_sdata_i,
    output logic                     tx_underrun_o
);

    localparam int TXF_W   = NUM_CH * TX_W;
    localparam int RXF_W   = NUM_CH * RX_W;
    localparam int DIV_CW  = ($clog2(BCLK_DIV) < 1) ? 1 : $clog2(BCLK_DIV);
    localparam int BIT_CW  = ($clog2(SLOT_W) < 1) ? 1 : $clog2(SLOT_W);
    localparam int SLOT_CW = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH);

    localparam logic [DIV_CW-1:0]  DIV_LAST  = DIV_CW'(BCLK_DIV - 1);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(SLOT_W - 1);
    localparam logic [SLOT_CW-1:0] SLOT_LAST = SLOT_CW'(NUM_CH - 1);
    localparam logic [SLOT_CW-1:0] SLOT_HALF = SLOT_CW'(NUM_CH / 2);
    localparam logic [TXF_W-1:0]   TX_ONE    = TXF_W'(1);
    localparam logic [RXF_W-1:0]   RX_ONE    = RXF_W'(1);

    logic                run_q, run_d;
    logic [DIV_CW-1:0]   div_q, div_d;
    logic                bclk_q, bclk_d;
    logic [BIT_CW-1:0]   bit_q, bit_d;
    logic [SLOT_CW-1:0]  slot_q, slot_d;
    logic                lrclk_q, lrclk_d;
    logic                dac_q, dac_d;
    logic [TXF_W-1:0]    tx_frame_q, tx_frame_d;
    logic [TXF_W-1:0]    hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                underrun_q, underrun_d;
    logic [RXF_W-1:0]    rx_acc_q, rx_acc_d;
    logic [RXF_W-1:0]    rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;

    logic                frame_load;
    logic                handshake;
    logic [SLOT_CW-1:0]  lr_slot;
    int                  tx_idx;
    int                  rx_idx;

    assign handshake = tx_valid_i & ~hold_full_q;

    always_comb begin
        run_d       = run_q;
        div_d       = div_q;
        bclk_d      = bclk_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        lrclk_d     = lrclk_q;
        dac_d       = dac_q;
        tx_frame_d  = tx_frame_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;
        rx_acc_d    = rx_acc_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_load  = 1'b0;
        lr_slot     = '0;
        tx_idx      = 0;
        rx_idx      = 0;

        if (!enable_i) begin
            run_d    = 1'b0;
            div_d    = '0;
            bclk_d   = 1'b0;
            bit_d    = '0;
            slot_d   = '0;
            lrclk_d  = 1'b0;
            dac_d    = 1'b0;
            rx_acc_d = '0;
        end else if (!run_q) begin
            run_d      = 1'b1;
            div_d      = '0;
            bclk_d     = 1'b0;
            bit_d      = '0;
            slot_d     = '0;
            frame_load = 1'b1;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            if (!bclk_q) begin
                // Rising edge: capture ADC bit, MSB of each slot lands in the top of its lane.
                if (int'(bit_q) < RX_W) begin
                    rx_idx   = int'(slot_q) * RX_W + RX_W - 1 - int'(bit_q);
                    rx_acc_d = (rx_acc_q & ~(RX_ONE << rx_idx))
                             | ({{(RXF_W-1){1'b0}}, adc_sdata_i} << rx_idx);
                end
                if (bit_q == BIT_LAST && slot_q == SLOT_LAST) begin
                    rx_data_d  = rx_acc_d;
                    rx_valid_d = 1'b1;
                end
            end else begin
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (slot_q == SLOT_LAST) begin
                        slot_d     = '0;
                        frame_load = 1'b1;
                    end else begin
                        slot_d = slot_q + SLOT_CW'(1);
                    end
                end else begin
                    bit_d = bit_q + BIT_CW'(1);
                end
            end
        end else begin
            div_d = div_q + DIV_CW'(1);
        end

        if (frame_load) begin
            if (hold_full_q) begin
                tx_frame_d  = hold_q;
                hold_full_d = 1'b0;
            end else if (tx_valid_i) begin
                tx_frame_d = tx_data_i;
            end else begin
                tx_frame_d = '0;
                underrun_d = 1'b1;
            end
        end else if (handshake) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end

        // Serial outputs follow the post-edge position; they only move at falling edges or start.
        if (enable_i) begin
            if (int'(bit_d) < TX_W) begin
                tx_idx = int'(slot_d) * TX_W + TX_W - 1 - int'(bit_d);
                dac_d  = |(tx_frame_d & (TX_ONE << tx_idx));
            end else begin
                dac_d = 1'b0;
            end
            if (I2S_MODE != 0 && bit_d == BIT_LAST) begin
                lr_slot = (slot_d == SLOT_LAST) ? '0 : slot_d + SLOT_CW'(1);
            end else begin
                lr_slot = slot_d;
            end
            lrclk_d = (lr_slot >= SLOT_HALF);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q       <= 1'b0;
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_q       <= '0;
            slot_q      <= '0;
            lrclk_q     <= 1'b0;
            dac_q       <= 1'b0;
            tx_frame_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            rx_acc_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            run_q       <= run_d;
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            lrclk_q     <= lrclk_d;
            dac_q       <= dac_d;
            tx_frame_q  <= tx_frame_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            rx_acc_q    <= rx_acc_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign tx_ready_o    = ~hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign bclk_o        = bclk_q;
    assign lrclk_o       = lrclk_q;
    assign dac_sdata_o   = dac_q;
    assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_student_iis_tdm_transceiver.sv
// tb/tb_student_iis_tdm_transceiver.sv - directed bench for student_iis_tdm_transceiver
// Default 2-channel I2S instance plus an 8-channel left-justified instance, both in loopback.
module tb_student_iis_tdm_transceiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst = 1'b1, en = 1'b0, txv = 1'b0;
    logic [47:0] txd = '0;
    logic        txr, rxv, bclk, lrclk, dac, und;
    logic [31:0] rxd;

    student_iis_tdm_transceiver u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en),
        .tx_data_i(txd), .tx_valid_i(txv), .tx_ready_o(txr),
        .rx_data_o(rxd), .rx_valid_o(rxv),
        .bclk_o(bclk), .lrclk_o(lrclk), .dac_sdata_o(dac), .adc_sdata_i(dac),
        .tx_underrun_o(und)
    );

    logic         rst8 = 1'b1, en8 = 1'b0, txv8 = 1'b0;
    logic [191:0] txd8 = '0;
    logic         txr8, rxv8, bclk8, lrclk8, dac8, und8;
    logic [127:0] rxd8;

    student_iis_tdm_transceiver #(.NUM_CH(8), .I2S_MODE(0)) u_dut8 (
        .clk_i(clk), .rst_i(rst8), .enable_i(en8),
        .tx_data_i(txd8), .tx_valid_i(txv8), .tx_ready_o(txr8),
        .rx_data_o(rxd8), .rx_valid_o(rxv8),
        .bclk_o(bclk8), .lrclk_o(lrclk8), .dac_sdata_o(dac8), .adc_sdata_i(dac8),
        .tx_underrun_o(und8)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; txv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_rxv(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rxv !== 1'b1 && n < limit);
    endtask

    task automatic wait_rxv8(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rxv8 !== 1'b1 && n < limit);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bclk !== 1'b0)  begin errors++; $display("FAIL reset_bclk got %b exp 0", bclk); end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk got %b exp 0", lrclk); end
        checks++; if (dac !== 1'b0)   begin errors++; $display("FAIL reset_dac got %b exp 0", dac); end
        checks++; if (txr !== 1'b1)   begin errors++; $display("FAIL reset_tx_ready got %b exp 1", txr); end
        checks++; if (rxv !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rxv); end
        checks++; if (rxd !== 32'h0)  begin errors++; $display("FAIL reset_rx_data got %h exp 0", rxd); end
        checks++; if (und !== 1'b0)   begin errors++; $display("FAIL reset_underrun got %b exp 0", und); end
    endtask

    task automatic test_underrun();
        int dac_ones;
        int toggles;
        logic prev_bclk;
        do_reset();
        en = 1'b1;
        @(negedge clk);
        checks++; if (und !== 1'b1) begin errors++; $display("FAIL underrun_first_load got %b exp 1", und); end
        dac_ones = 0; toggles = 0; prev_bclk = bclk;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (dac !== 1'b0) dac_ones++;
            if (bclk !== prev_bclk) toggles++;
            prev_bclk = bclk;
        end
        checks++; if (dac_ones !== 0) begin errors++; $display("FAIL underrun_dac_zero got %0d nonzero cycles exp 0", dac_ones); end
        checks++; if (toggles !== 128) begin errors++; $display("FAIL bclk_toggle_count got %0d exp 128", toggles); end
        checks++; if (und !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b exp 1", und); end
    endtask

    task automatic test_loopback();
        int n;
        do_reset();
        txd = {24'h123456, 24'hABCDEF}; txv = 1'b1; en = 1'b1;
        wait_rxv(1200, n);
        checks++; if (rxv !== 1'b1) begin errors++; $display("FAIL loop_first_valid timeout after %0d cycles", n); end
        checks++; if (rxd !== 32'h1234ABCD) begin errors++; $display("FAIL loop_data1 got %h exp 1234abcd", rxd); end
        wait_rxv(1000, n);
        checks++; if (n !== 512) begin errors++; $display("FAIL loop_period got %0d exp 512", n); end
        checks++; if (rxd !== 32'h1234ABCD) begin errors++; $display("FAIL loop_data2 got %h exp 1234abcd", rxd); end
        @(negedge clk);
        checks++; if (rxv !== 1'b0) begin errors++; $display("FAIL loop_pulse_width got %b exp 0", rxv); end
        checks++; if (und !== 1'b0) begin errors++; $display("FAIL loop_no_underrun got %b exp 0", und); end
    endtask

    task automatic test_i2s_msb();
        logic prev_lr;
        logic dac_s [512];
        logic bclk_s [512];
        int found;
        int ones;
        do_reset();
        txd = {24'h000000, 24'h800000}; txv = 1'b1; en = 1'b1;
        @(negedge clk);
        prev_lr = lrclk; found = 0;
        for (int i = 0; i < 1200 && found == 0; i++) begin
            @(negedge clk);
            if (prev_lr === 1'b1 && lrclk === 1'b0) found = 1;
            prev_lr = lrclk;
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL i2s_lrclk_fall timeout got %0d exp 1", found); end
        for (int i = 0; i < 512; i++) begin
            if (i != 0) @(negedge clk);
            dac_s[i] = dac; bclk_s[i] = bclk;
        end
        ones = 0;
        for (int i = 0; i < 512; i++) if (dac_s[i] === 1'b1) ones++;
        checks++; if (bclk_s[0] !== 1'b0) begin errors++; $display("FAIL i2s_bclk_at_fall got %b exp 0", bclk_s[0]); end
        checks++; if (bclk_s[3] !== 1'b0) begin errors++; $display("FAIL i2s_bclk_low_half got %b exp 0", bclk_s[3]); end
        checks++; if (bclk_s[4] !== 1'b1) begin errors++; $display("FAIL i2s_bclk_high_half got %b exp 1", bclk_s[4]); end
        checks++; if (dac_s[7] !== 1'b0) begin errors++; $display("FAIL i2s_dac_delay got %b exp 0", dac_s[7]); end
        checks++; if (dac_s[8] !== 1'b1) begin errors++; $display("FAIL i2s_dac_msb_start got %b exp 1", dac_s[8]); end
        checks++; if (dac_s[15] !== 1'b1) begin errors++; $display("FAIL i2s_dac_msb_end got %b exp 1", dac_s[15]); end
        checks++; if (dac_s[16] !== 1'b0) begin errors++; $display("FAIL i2s_dac_after_msb got %b exp 0", dac_s[16]); end
        checks++; if (ones !== 8) begin errors++; $display("FAIL i2s_dac_high_cycles got %0d exp 8", ones); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        txd = {24'hC0FFEE, 24'h5A5A5A}; txv = 1'b1;
        @(negedge clk);
        txd = {24'h00BEEF, 24'h7E57AB};
        checks++; if (txr !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", txr); end
        repeat (3) @(negedge clk);
        checks++; if (txr !== 1'b0) begin errors++; $display("FAIL b2b_stall_hold got %b exp 0", txr); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (txr !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_load got %b exp 1", txr); end
        @(negedge clk);
        txv = 1'b0;
        checks++; if (txr !== 1'b0) begin errors++; $display("FAIL b2b_second_accepted got %b exp 0", txr); end
        wait_rxv(1200, n);
        checks++; if (rxd !== 32'hC0FF5A5A) begin errors++; $display("FAIL b2b_frame1 got %h exp c0ff5a5a", rxd); end
        wait_rxv(1000, n);
        checks++; if (rxd !== 32'h00BE7E57) begin errors++; $display("FAIL b2b_frame2 got %h exp 00be7e57", rxd); end
        checks++; if (und !== 1'b0) begin errors++; $display("FAIL b2b_no_underrun got %b exp 0", und); end
        repeat (10) @(negedge clk);
        checks++; if (und !== 1'b1) begin errors++; $display("FAIL b2b_third_load_underrun got %b exp 1", und); end
    endtask

    task automatic test_midframe_reset();
        int n;
        do_reset();
        txd = {24'h123456, 24'hABCDEF}; txv = 1'b1; en = 1'b1;
        wait_rxv(1200, n);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({bclk, lrclk, dac, rxv} !== 4'b0000) begin errors++; $display("FAIL mid_reset_serial got %b exp 0000", {bclk, lrclk, dac, rxv}); end
        checks++; if (rxd !== 32'h0) begin errors++; $display("FAIL mid_reset_rx_data got %h exp 0", rxd); end
        checks++; if ({txr, und} !== 2'b10) begin errors++; $display("FAIL mid_reset_ready_und got %b exp 10", {txr, und}); end
        @(negedge clk);
        checks++; if ({dac, bclk, lrclk} !== 3'b100) begin errors++; $display("FAIL mid_restart_frame got %b exp 100", {dac, bclk, lrclk}); end
        wait_rxv(1200, n);
        checks++; if (n !== 508) begin errors++; $display("FAIL mid_restart_latency got %0d exp 508", n); end
        checks++; if (rxd !== 32'h1234ABCD) begin errors++; $display("FAIL mid_restart_data got %h exp 1234abcd", rxd); end
    endtask

    task automatic test_tdm8();
        logic [127:0] exp8;
        int n;
        int k;
        @(negedge clk);
        rst8 = 1'b1; en8 = 1'b0;
        @(negedge clk);
        rst8 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            txd8[c*24 +: 24] = {8'(17 * (c + 1)), 8'hC3, 8'(c)};
            exp8[c*16 +: 16] = {8'(17 * (c + 1)), 8'hC3};
        end
        txv8 = 1'b1; en8 = 1'b1;
        wait_rxv8(2500, n);
        checks++; if (rxd8 !== exp8) begin errors++; $display("FAIL tdm8_data1 got %h exp %h", rxd8, exp8); end
        checks++; if (lrclk8 !== 1'b1) begin errors++; $display("FAIL tdm8_lrclk_slot7 got %b exp 1", lrclk8); end
        k = 0;
        for (int i = 1; i <= 2100 && k == 0; i++) begin
            @(negedge clk);
            if (i == 3) begin checks++; if (lrclk8 !== 1'b1) begin errors++; $display("FAIL tdm8_lrclk_end_frame got %b exp 1", lrclk8); end end
            if (i == 4) begin checks++; if (lrclk8 !== 1'b0) begin errors++; $display("FAIL tdm8_lrclk_slot0 got %b exp 0", lrclk8); end end
            if (i == 1027) begin checks++; if (lrclk8 !== 1'b0) begin errors++; $display("FAIL tdm8_lrclk_slot3 got %b exp 0", lrclk8); end end
            if (i == 1028) begin checks++; if (lrclk8 !== 1'b1) begin errors++; $display("FAIL tdm8_lrclk_slot4 got %b exp 1", lrclk8); end end
            if (rxv8 === 1'b1) k = i;
        end
        checks++; if (k !== 2048) begin errors++; $display("FAIL tdm8_period got %0d exp 2048", k); end
        checks++; if (rxd8 !== exp8) begin errors++; $display("FAIL tdm8_data2 got %h exp %h", rxd8, exp8); end
        checks++; if (und8 !== 1'b0) begin errors++; $display("FAIL tdm8_no_underrun got %b exp 0", und8); end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_loopback();
        test_i2s_msb();
        test_back_to_back();
        test_midframe_reset();
        test_tdm8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/student_iis_tdm_transceiver.md
STUDENT_IIS_TDM_TRANSCEIVER -- requirements
Module: student_iis_tdm_transceiver

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning channel slots per frame (even, 2..8).
REQ-002 SHALL have parameter TX_W, default 24, meaning DAC sample width per channel.
REQ-003 SHALL have parameter RX_W, default 16, meaning ADC sample width per channel.
REQ-004 SHALL have parameter SLOT_W, default 32, meaning BCLK periods per slot (>= max(TX_W,RX_W)).
REQ-005 SHALL have parameter BCLK_DIV, default 4, meaning clk_i cycles per BCLK half-period (>= 2).
REQ-006 SHALL have parameter I2S_MODE, default 1, meaning 1 = data delayed one BCLK after LRCLK edge, 0 = left-justified.
REQ-007 SHALL have ports: clk_i  in  1  system clock; rst_i  in  1  reset, synchronous, active-high.
REQ-008 SHALL have enable_i  in  1  run serial engine.
REQ-009 SHALL have tx_data_i  in  NUM_CH*TX_W  frame to transmit, channel 0 in LSBs; tx_valid_i  in  1; tx_ready_o  out  1.
REQ-010 SHALL have rx_data_o  out  NUM_CH*RX_W  last received frame, channel 0 in LSBs; rx_valid_o  out  1  one-cycle strobe.
REQ-011 SHALL have bclk_o  out  1; lrclk_o  out  1; dac_sdata_o  out  1; adc_sdata_i  in  1 (synchronous to bclk_o).
REQ-012 SHALL have tx_underrun_o  out  1  sticky, frame loaded with no data available.

Function
REQ-013 SHALL toggle bclk_o every BCLK_DIV clk_i cycles while enable_i=1; frame = NUM_CH*SLOT_W BCLK periods.
REQ-014 SHALL drive lrclk_o low for slots 0..NUM_CH/2-1, high for remaining slots; edges coincide with bclk_o falling edges.
REQ-015 SHALL shift dac_sdata_o MSB-first, changing only on bclk_o falling edges; each slot carries TX_W data bits then zeros to SLOT_W.
REQ-016 SHALL, with I2S_MODE=1, place slot bit 0 one BCLK period after the lrclk_o/frame edge; with I2S_MODE=0 coincident with it.
REQ-017 SHALL sample adc_sdata_i on bclk_o rising edges using the same bit alignment as the DAC; first RX_W bits of each slot kept MSB-first, rest discarded.
REQ-018 SHALL update rx_data_o and pulse rx_valid_o for one clk_i cycle, one cycle after the rising edge sampling the last bit position of slot NUM_CH-1.
REQ-019 SHALL hold a one-frame TX holding register; tx_ready_o=1 iff holding register empty; transfer on tx_valid_i & tx_ready_o.
REQ-020 SHALL, at each frame load (falling edge starting bit 0 of slot 0), move holding register into the shift frame and mark it empty.
REQ-021 SHALL, on frame load with holding empty and simultaneous handshake, load incoming tx_data_i directly (bypass), no underrun.
REQ-022 SHALL, on frame load with no data available, transmit an all-zero frame and set tx_underrun_o (cleared only by rst_i).
REQ-023 SHALL, when enable_i falls, next cycle drive bclk_o, lrclk_o, dac_sdata_o low, clear divider/bit/slot counters and RX shift state; holding register and rx_data_o retained.
REQ-024 SHALL, when enable_i rises, start a new frame at slot 0 bit 0 with bclk_o low, performing a frame load in that cycle.
REQ-025 SHALL treat tx_underrun_o as not set on the very first frame load after reset if data is not yet available? No: underrun applies to every load, including the first.

Reset
REQ-026 SHALL, with rst_i=1 at a clk_i edge, set bclk_o=0, lrclk_o=0, dac_sdata_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, tx_underrun_o=0, holding empty, all counters 0.
REQ-027 SHALL abort any frame in progress on reset; with enable_i=1 the first frame load occurs the cycle after rst_i deasserts.

Verification (NUM_CH=2, TX_W=24, RX_W=16, SLOT_W=32, BCLK_DIV=4 unless stated; frame = 512 clk_i cycles)
REQ-028 Loopback dac_sdata_o->adc_sdata_i, send {24'h123456,24'hABCDEF} -> rx_data_o={16'h1234,16'hABCD}, rx_valid_o every 512 cycles.
REQ-029 No tx_valid_i after reset -> dac_sdata_o constant 0, tx_underrun_o=1 from first frame load, stays 1.
REQ-030 I2S_MODE=1, ch0=24'h800000 -> dac_sdata_o high exactly one BCLK period after lrclk_o falls, for one BCLK period.
REQ-031 Two back-to-back tx words -> second stalls tx_ready_o=0 until next frame load, then accepted; no underrun.
REQ-032 NUM_CH=8, I2S_MODE=0 -> lrclk_o high during slots 4..7, rx_valid_o period 2048 cycles, loopback channel order preserved.
REQ-033 rst_i pulsed one cycle mid-frame (cycle 300) -> all outputs at reset values next cycle, new frame starts following cycle.
